// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register sequencer.
package usr_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_ROTR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/usr_core.sv
// WIDTH-bit universal shift register: hold, shift right, shift left, parallel load.
module usr_core
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_s,
  input  logic [WIDTH-1:0] din,
  input  logic             ser_right,
  input  logic             ser_left,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else begin
      case (mode_s)
        MODE_RIGHT: q <= {ser_right, q[WIDTH-1:1]};
        MODE_LEFT:  q <= {q[WIDTH-2:0], ser_left};
        MODE_LOAD:  q <= din;
        default:    q <= q;
      endcase
    end
  end

endmodule

// File: rtl/usr_shift_ctrl.sv
// Command sequencer driving the universal shift register mode select for an exact cycle count.
module usr_shift_ctrl
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] din,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic [1:0]       mode_s,
  output logic             busy,
  output logic             done
);

  state_e           state;
  op_e              op_r;
  mode_e            mode_r;
  logic [WIDTH-1:0] din_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic             ready_r;
  logic             ser_right;

  // Outputs are updated together with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      op_r    <= OP_LOAD;
      mode_r  <= MODE_HOLD;
      din_r   <= '0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_r    <= op_e'(cmd_op);
            din_r   <= din;
            cnt_r   <= cmd_cnt;
            busy_r  <= 1'b1;
            ready_r <= 1'b0;
            if (op_e'(cmd_op) == OP_LOAD) begin
              state  <= ST_LOAD;
              mode_r <= MODE_LOAD;
            end else if (cmd_cnt != CNT_W'(0)) begin
              state  <= ST_SHIFT;
              mode_r <= (op_e'(cmd_op) == OP_SHL) ? MODE_LEFT : MODE_RIGHT;
            end else begin
              state  <= ST_DONE;
              done_r <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          state  <= ST_DONE;
          mode_r <= MODE_HOLD;
          done_r <= 1'b1;
        end
        ST_SHIFT: begin
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state  <= ST_DONE;
            mode_r <= MODE_HOLD;
            done_r <= 1'b1;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Rotate feeds the outgoing LSB back into the MSB.
  assign ser_right = (op_r == OP_ROTR) ? q[0] : ser_in;

  usr_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .mode_s   (mode_r),
    .din      (din_r),
    .ser_right(ser_right),
    .ser_left (ser_in),
    .q        (q)
  );

  assign ser_out   = (state == ST_SHIFT) ? ((op_r == OP_SHL) ? q[WIDTH-1] : q[0]) : 1'b0;
  assign mode_s    = mode_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign cmd_ready = ready_r;

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Scoreboard bench for usr_shift_ctrl: per-busy-cycle expectations queued by stimulus, checked by a monitor.
module tb_usr_shift_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_cnt;
  logic [3:0] din;
  logic       ser_in;
  logic [3:0] q;
  logic       ser_out;
  logic [1:0] mode_s;
  logic       busy;
  logic       done;

  typedef struct {
    logic [1:0] mode;
    logic       so;
    logic       dn;
    logic [3:0] qv;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  usr_shift_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_cnt  (cmd_cnt),
    .din      (din),
    .ser_in   (ser_in),
    .q        (q),
    .ser_out  (ser_out),
    .mode_s   (mode_s),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] m, input logic s, input logic d, input logic [3:0] qq);
    exp_t e;
    e.mode = m; e.so = s; e.dn = d; e.qv = qq;
    sb.push_back(e);
  endtask

  // Monitor: every busy cycle must match the next queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (busy) begin
        if (sb.size() == 0) begin
          check("unexpected_busy", 8'(busy), 8'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("mode_s", 8'(mode_s), 8'(e.mode));
          check("ser_out", 8'(ser_out), 8'(e.so));
          check("done", 8'(done), 8'(e.dn));
          check("q", 8'(q), 8'(e.qv));
          check("cmd_ready_busy", 8'(cmd_ready), 8'(0));
        end
      end else begin
        check("idle_done", 8'(done), 8'(0));
        check("idle_mode", 8'(mode_s), 8'(0));
        check("idle_ready", 8'(cmd_ready), 8'(1));
      end
    end
  end

  task automatic wait_ready();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
    end
    if (!ok) check("ready_timeout", 8'(0), 8'(1));
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
    if (!ok) check("done_timeout", 8'(0), 8'(1));
  endtask

  // Issue one command at a negedge, drop valid and scramble din after E0.
  task automatic issue(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] d, input logic si);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; din = d; ser_in = si;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    din = ~d;
    cmd_cnt = 3'd7;
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_cnt = 3'd0; din = 4'h0; ser_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_q", 8'(q), 8'(0));
    check("rst_busy", 8'(busy), 8'(0));
    check("rst_done", 8'(done), 8'(0));
    check("rst_ready", 8'(cmd_ready), 8'(1));
    check("rst_mode", 8'(mode_s), 8'(0));

    // LOAD 1011; din changed after accept must not matter
    push(2'b11, 1'b0, 1'b0, 4'b0000);
    push(2'b00, 1'b0, 1'b1, 4'b1011);
    issue(2'b00, 3'd0, 4'b1011, 1'b0);
    wait_done();

    // SHR 2 with ser_in=1, valid held high: second command (cnt=0) accepted only after IDLE
    push(2'b01, 1'b1, 1'b0, 4'b1011);
    push(2'b01, 1'b1, 1'b0, 4'b1101);
    push(2'b00, 1'b0, 1'b1, 4'b1110);
    push(2'b00, 1'b0, 1'b1, 4'b1110);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_cnt = 3'd2; ser_in = 1'b1;
    @(posedge clk);
    #1 cmd_cnt = 3'd0;
    wait_done();
    wait_done();
    cmd_valid = 1'b0;

    // SHL 3 with ser_in=0 from 1110
    push(2'b10, 1'b1, 1'b0, 4'b1110);
    push(2'b10, 1'b1, 1'b0, 4'b1100);
    push(2'b10, 1'b1, 1'b0, 4'b1000);
    push(2'b00, 1'b0, 1'b1, 4'b0000);
    issue(2'b10, 3'd3, 4'h0, 1'b0);
    wait_done();

    // Reload 1011, then ROTR 4 restores it
    push(2'b11, 1'b0, 1'b0, 4'b0000);
    push(2'b00, 1'b0, 1'b1, 4'b1011);
    issue(2'b00, 3'd0, 4'b1011, 1'b0);
    wait_done();
    push(2'b01, 1'b1, 1'b0, 4'b1011);
    push(2'b01, 1'b1, 1'b0, 4'b1101);
    push(2'b01, 1'b0, 1'b0, 4'b1110);
    push(2'b01, 1'b1, 1'b0, 4'b0111);
    push(2'b00, 1'b0, 1'b1, 4'b1011);
    issue(2'b11, 3'd4, 4'h0, 1'b1);
    wait_done();

    // ROTR 1 with ser_in=0 (ignored)
    push(2'b01, 1'b1, 1'b0, 4'b1011);
    push(2'b00, 1'b0, 1'b1, 4'b1101);
    issue(2'b11, 3'd1, 4'h0, 1'b0);
    wait_done();

    // SHR 0: straight to DONE, q unchanged
    push(2'b00, 1'b0, 1'b1, 4'b1101);
    issue(2'b01, 3'd0, 4'h0, 1'b1);
    wait_done();

    // SHL 5 aborted by reset after two shifts
    push(2'b10, 1'b1, 1'b0, 4'b1101);
    push(2'b10, 1'b1, 1'b0, 4'b1011);
    issue(2'b10, 3'd5, 4'h0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_q", 8'(q), 8'(0));
    check("abort_busy", 8'(busy), 8'(0));
    check("abort_done", 8'(done), 8'(0));
    check("abort_ready", 8'(cmd_ready), 8'(1));
    check("abort_mode", 8'(mode_s), 8'(0));
    check("abort_ser_out", 8'(ser_out), 8'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(negedge clk);
    check("sb_empty", 8'(sb.size()), 8'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
